rr_mux_arbiter: RTL and testbench

- Parametrised successor to the team's combinational 4-to-1 32-bit mux: NUM_CH input channels of WIDTH bits, each with a valid/ready handshake.
- Arbitrates between requesting channels per beat, in round-robin or fixed-priority mode.
- Registers the winning word into a single output stage with valid/ready backpressure.
- Sits between multiple producers (e.g. ALU result sources) and one shared consumer bus.

---
 rtl/rr_mux_arbiter.sv | 115 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// NUM_CH-way valid/ready arbiter (round-robin or fixed priority) feeding one registered output
// stage. Define RR_MUX_LOCK_EN to add in_last and hold the grant across multi-beat packets.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
`endif
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load_en;
    logic              w_found;
    logic              w_xfer;
    logic              w_ptr_adv;
    logic [NUM_CH-1:0] w_grant;
    logic [SEL_W-1:0]  w_gidx;
    logic [SEL_W-1:0]  w_idx;
    logic [SEL_W-1:0]  w_ptr_next;
    logic [WIDTH-1:0]  w_gdata;

`ifdef RR_MUX_LOCK_EN
    logic              r_lock;
    logic [SEL_W-1:0]  r_lock_ch;
`endif

    // Scan order starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = mode ? SEL_W'(k) : SEL_W'((32'(r_rr_ptr) + k) % NUM_CH);
            if (!w_found && in_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gidx         = w_idx;
            end
        end
`ifdef RR_MUX_LOCK_EN
        if (r_lock) begin
            w_grant            = '0;
            w_gidx             = r_lock_ch;
            w_grant[r_lock_ch] = in_valid[r_lock_ch];
        end
`endif
    end

    assign w_load_en  = !r_out_valid || out_ready;
    assign in_ready   = (rst_n && w_load_en) ? w_grant : '0;
    assign w_xfer     = |in_ready;
    assign w_gdata    = in_data[32'(w_gidx) * WIDTH +: WIDTH];
    assign w_ptr_next = (32'(w_gidx) == NUM_CH - 1) ? '0 : w_gidx + 1'b1;

`ifdef RR_MUX_LOCK_EN
    assign w_ptr_adv  = w_xfer && in_last[w_gidx];
`else
    assign w_ptr_adv  = w_xfer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            // With load_en high the stage either takes a new beat or empties.
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_gdata;
                    r_out_sel  <= w_gidx;
                end
            end
            if (w_ptr_adv) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            r_lock    <= !in_last[w_gidx];
            r_lock_ch <= w_gidx;
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: stimulus pushes expected beats into a queue, a negedge
// monitor pops and compares each beat the consumer accepts.
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [31:0]             ch_data [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid = '0;
    logic [NUM_CH-1:0]       in_ready;
`ifdef RR_MUX_LOCK_EN
    logic [NUM_CH-1:0]       in_last = '1;
`endif
    logic                    mode = 1'b0;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready = 1'b1;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    rr_mux_arbiter #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last  (in_last),
`endif
        .mode     (mode),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = ch_data[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] s);
        beat_t b;
        b.d = d;
        b.s = s;
        exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every beat the consumer takes must match the head of the queue.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %h sel %0d, expected none",
                         out_data, out_sel);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.d);
                check("beat_sel", 32'(out_sel), 32'(e.s));
            end
        end
    end

    initial begin
        int cnt0;
        int cnt2;
        logic [3:0] rdy;
        for (int i = 0; i < NUM_CH; i++) ch_data[i] = '0;

        // Reset state, with requests present to show in_ready is gated.
        in_valid = 4'b1111;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin fairness over all four channels.
        for (int i = 0; i < NUM_CH; i++) ch_data[i] = 32'hA0 + 32'(i);
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) push(32'hA0 + 32'(k % 4), 2'(k % 4));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk); #1;
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end
        idle(2);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Fixed priority: ch1 always beats ch3.
        mode = 1'b1;
        ch_data[1] = 32'h11;
        ch_data[3] = 32'h33;
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) push(32'h11, 2'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fp_in_ready", 32'(in_ready), 32'b0010);
            @(posedge clk); #1;
        end
        idle(2);
        mode = 1'b0;

        // Backpressure: beat held, then next beat loads as the old one leaves.
        out_ready = 1'b0;
        ch_data[2] = 32'h22;
        in_valid = 4'b0100;
        push(32'h22, 2'd2);
        @(posedge clk); #1;
        ch_data[2] = 32'h23;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", out_data, 32'h22);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        push(32'h23, 2'd2);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'b0100);
        @(posedge clk); #1;
        check("bp_nobubble_data", out_data, 32'h23);
        check("bp_nobubble_valid", 32'(out_valid), 32'd1);
        idle(2);

        // Wrap/skip from rr_ptr=3.
        ch_data[1] = 32'h31;
        in_valid = 4'b0010;
        push(32'h31, 2'd1);
        @(negedge clk);
        check("wrap_ch1_ready", 32'(in_ready), 32'b0010);
        @(posedge clk); #1;
        ch_data[0] = 32'h30;
        in_valid = 4'b0001;
        push(32'h30, 2'd0);
        @(negedge clk);
        check("wrap_ch0_ready", 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        ch_data[1] = 32'h32;
        in_valid = 4'b1111;
        push(32'h32, 2'd1);
        @(negedge clk);
        check("wrap_ptr1_ready", 32'(in_ready), 32'b0010);
        @(posedge clk); #1;
        idle(2);

        // Multi-beat packet on ch2 competing with ch0 (rr_ptr=2 here).
        cnt0 = 0;
        cnt2 = 0;
        ch_data[0] = 32'h40;
        ch_data[2] = 32'h50;
`ifdef RR_MUX_LOCK_EN
        in_last = 4'b1011;
        push(32'h50, 2'd2); push(32'h51, 2'd2); push(32'h52, 2'd2);
        push(32'h40, 2'd0); push(32'h41, 2'd0); push(32'h42, 2'd0);
`else
        push(32'h50, 2'd2); push(32'h40, 2'd0); push(32'h51, 2'd2);
        push(32'h41, 2'd0); push(32'h52, 2'd2); push(32'h42, 2'd0);
`endif
        in_valid = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy[0]) begin
                cnt0++;
                ch_data[0] = 32'h40 + 32'(cnt0);
            end
            if (rdy[2]) begin
                cnt2++;
                ch_data[2] = 32'h50 + 32'(cnt2);
                if (cnt2 == 3) in_valid[2] = 1'b0;
            end
`ifdef RR_MUX_LOCK_EN
            in_last[2] = (cnt2 == 2);
`endif
        end
        idle(2);
`ifdef RR_MUX_LOCK_EN
        in_last = '1;
`endif

        // Reset while a beat is stalled in the output register.
        out_ready = 1'b0;
        ch_data[0] = 32'h77;
        in_valid = 4'b0001;
        @(posedge clk); #1;
        in_valid = '0;
        @(posedge clk); #1;
        check("stall_out_valid", 32'(out_valid), 32'd1);
        in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_out_sel", 32'(out_sel), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) ch_data[i] = 32'hC0 + 32'(i);
        for (int k = 0; k < 5; k++) push(32'hC0 + 32'(k % 4), 2'(k % 4));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk); #1;
        end
        idle(3);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
